axi_read_slave: RTL

AXI3-style read responder for the slave side of the AXI top design.
- Accepts one read address (AR) transaction at a time and returns the burst on the R channel.
- Read data comes from the 4 KB byte-addressed slave memory.
- It is the counterpart of the master read-address initiator and sits beside the slave write logic inside the top design.

---
 rtl/axi_read_slave.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_slave.sv
// AXI3 read responder over a flat byte memory; AR handshake to first RVALID is 1 cycle, beats held while RREADY is low.
// Define AXI_RD_SLVERR_EN to return SLVERR for out-of-range beats and reserved bursts.
module axi_read_slave #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 3,
  parameter int MEM_BYTES = 4096
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [MEM_BYTES*8-1:0] slave_mem,
  input  logic [WIDTH/8-1:0]     ARID,
  input  logic [WIDTH-1:0]       ARADDR,
  input  logic [WIDTH/8-1:0]     ARLEN,
  input  logic [SIZE-1:0]        ARSIZE,
  input  logic [SIZE-2:0]        ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [WIDTH/8-1:0]     RID,
  output logic [WIDTH-1:0]       RDATA,
  output logic [SIZE-2:0]        RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY
);

  localparam int NB  = WIDTH / 8;
  localparam int LG  = $clog2(NB);
  localparam int MAW = $clog2(MEM_BYTES);
  localparam int LW  = WIDTH / 8;
  localparam int BW  = SIZE - 1;

  localparam logic [BW-1:0] B_FIXED = BW'(0);
  localparam logic [BW-1:0] B_WRAP  = BW'(2);
`ifdef AXI_RD_SLVERR_EN
  localparam logic [BW-1:0] B_RSVD  = BW'(3);
`endif
  localparam logic [BW-1:0] R_OKAY   = BW'(0);
  localparam logic [BW-1:0] R_SLVERR = BW'(2);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [SIZE-1:0]  size_q, size_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [LW-1:0]    cnt_q, cnt_d;

  logic             arready_d, rvalid_d, rlast_d;
  logic [LW-1:0]    rid_d;
  logic [WIDTH-1:0] rdata_d;
  logic [BW-1:0]    rresp_d;

  logic             ld;
  logic [WIDTH-1:0] ld_addr;
  logic [SIZE-1:0]  ld_size;
  logic [BW-1:0]    ld_burst;
  logic [WIDTH-1:0] beat;
  logic             err;

  function automatic logic [SIZE-1:0] clamp_size(input logic [SIZE-1:0] s);
    return (s > SIZE'(LG)) ? SIZE'(LG) : s;
  endfunction

  // WRAP is only legal for 2, 4, 8 or 16 beats; anything else falls back to INCR.
  function automatic logic wrap_ok(input logic [LW-1:0] len);
    return ((len & (len + LW'(1))) == '0) && (len != '0);
  endfunction

  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] addr,
                                                  input logic [SIZE-1:0]  size,
                                                  input logic [LW-1:0]    len,
                                                  input logic [BW-1:0]    burst);
    logic [WIDTH-1:0] nbytes, aligned, span, bnd, inc;
    nbytes  = WIDTH'(1) << size;
    aligned = addr & ~(nbytes - WIDTH'(1));
    span    = nbytes * (WIDTH'(len) + WIDTH'(1));
    bnd     = aligned & ~(span - WIDTH'(1));
    inc     = aligned + nbytes;
    if (burst == B_FIXED)
      return addr;
    else if (burst == B_WRAP && wrap_ok(len))
      return (inc == bnd + span) ? bnd : inc;
    else
      return inc;
  endfunction

  // Lanes from the start byte up to the end of the size-aligned window carry data.
  function automatic logic [WIDTH-1:0] lane_data(input logic [MEM_BYTES*8-1:0] mem,
                                                  input logic [WIDTH-1:0]       addr,
                                                  input logic [SIZE-1:0]        size);
    logic [WIDTH-1:0] d, nbytes, win, base;
    logic [MAW-1:0]   midx;
    int               lo, hi;
    d      = '0;
    nbytes = WIDTH'(1) << size;
    win    = addr & ~(nbytes - WIDTH'(1));
    base   = addr & ~WIDTH'(NB - 1);
    lo     = int'(addr[LG-1:0]);
    hi     = int'(win[LG-1:0]) + int'(nbytes) - 1;
    for (int l = 0; l < NB; l++) begin
      midx = base[MAW-1:0] + MAW'(l);
      if (l >= lo && l <= hi)
        d[8*l +: 8] = mem[{midx, 3'b000} +: 8];
    end
    return d;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      ARREADY <= arready_d;
      RVALID  <= rvalid_d;
      RLAST   <= rlast_d;
      RID     <= rid_d;
      RDATA   <= rdata_d;
      RRESP   <= rresp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    arready_d = ARREADY;
    rvalid_d  = RVALID;
    rlast_d   = RLAST;
    rid_d     = RID;
    rdata_d   = RDATA;
    rresp_d   = RRESP;
    ld        = 1'b0;
    ld_addr   = addr_q;
    ld_size   = size_q;
    ld_burst  = burst_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        if (ARVALID && ARREADY) begin
          addr_d    = ARADDR;
          len_d     = ARLEN;
          size_d    = clamp_size(ARSIZE);
          burst_d   = ARBURST;
          cnt_d     = '0;
          rid_d     = ARID;
          ld        = 1'b1;
          ld_addr   = ARADDR;
          ld_size   = clamp_size(ARSIZE);
          ld_burst  = ARBURST;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (ARLEN == '0);
          state_d   = BURST;
        end
      end
      BURST: begin
        if (RVALID && RREADY) begin
          if (cnt_q == len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d   = cnt_q + LW'(1);
            addr_d  = next_addr(addr_q, size_q, len_q, burst_q);
            ld      = 1'b1;
            ld_addr = addr_d;
            rlast_d = ((cnt_q + LW'(1)) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    beat = lane_data(slave_mem, ld_addr, ld_size);
`ifdef AXI_RD_SLVERR_EN
    err = (ld_addr >= WIDTH'(MEM_BYTES)) || (ld_burst == B_RSVD);
`else
    err = 1'b0;
`endif
    if (ld) begin
      rdata_d = err ? '0 : beat;
      rresp_d = err ? R_SLVERR : R_OKAY;
    end
  end

endmodule
